unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 22 ++
 rtl/unidade_controle_if.sv | 24 ++
 rtl/unidade_controle_decodificador.sv | 38 +++
 rtl/unidade_controle.sv | 139 +++++++++++++
 tb/tb_unidade_controle.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared types and constants for the control unit: FSM states, opcode
// encodings and the controle values that select long (hi/lo) ALU operations.
package unidade_controle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

   localparam logic [5:0] OPC_NOP        = 6'b010000;
   localparam logic [5:0] OPC_HALT       = 6'b111111;
   localparam logic [1:0] OPC_ALU_PREFIX = 2'b00;

   // ALU selects that take LONG_OP_CYCLES in EXEC (64-bit hi/lo results)
   localparam logic [3:0] CTRL_LONG_HI = 4'hE;
   localparam logic [3:0] CTRL_LONG_LO = 4'hF;

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction-fetch bus between the control unit (master, drives the
// address) and the instruction memory (slave, returns the word).
interface unidade_controle_if #(
   parameter int PC_WIDTH = 8
);
   logic [31:0]         instr;
   logic                instr_valid;
   logic                instr_ready;
   logic [PC_WIDTH-1:0] pc;

   modport master (
      input  instr,
      input  instr_valid,
      output instr_ready,
      output pc
   );

   modport slave (
      output instr,
      output instr_valid,
      input  instr_ready,
      input  pc
   );
endinterface

// File: rtl/unidade_controle_decodificador.sv
// Purely combinational instruction decoder: splits the word into register
// fields and classifies the opcode as ALU / long ALU / NOP / HALT / illegal.
module decodificador_instr
   import unidade_controle_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_alu,
   output logic        is_long,
   output logic        is_nop,
   output logic        is_halt,
   output logic        is_illegal,
   output logic [5:0]  rd,
   output logic [5:0]  rs1,
   output logic [5:0]  rs2,
   output logic [3:0]  op
);
   logic [5:0] opcode;
   logic       unused_low_bits;

   assign opcode = instr[31:26];
   assign rd     = instr[25:20];
   assign rs1    = instr[19:14];
   assign rs2    = instr[13:8];

   // Low byte carries no meaning for the control unit
   assign unused_low_bits = ^instr[7:0];

   // Opcode classification; anything not ALU, NOP or HALT is illegal
   always_comb begin
      is_alu     = (opcode[5:4] == OPC_ALU_PREFIX);
      op         = is_alu ? opcode[3:0] : 4'h0;
      is_long    = is_alu && ((opcode[3:0] == CTRL_LONG_HI) || (opcode[3:0] == CTRL_LONG_LO));
      is_nop     = (opcode == OPC_NOP);
      is_halt    = (opcode == OPC_HALT);
      is_illegal = !(is_alu || is_nop || is_halt);
   end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches an instruction over the fetch bus,
// decodes it, drives the ALU select for one or LONG_OP_CYCLES cycles and
// issues a single register-file write per ALU instruction.
module unidade_controle
   import unidade_controle_pkg::*;
#(
   parameter int PC_WIDTH       = 8,
   parameter int LONG_OP_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   unidade_controle_if.master  bus,
   output logic [3:0]          controle,
   output logic                writeRegs,
   output logic [5:0]          endereco_escrita,
   output logic [5:0]          endereco_leitura1,
   output logic [5:0]          endereco_leitura2,
   output logic                busy,
   output logic                halted,
   output logic                illegal_op
);
   localparam int CNT_W = (LONG_OP_CYCLES > 1) ? $clog2(LONG_OP_CYCLES) : 1;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic       is_alu, is_long, is_nop, is_halt, is_illegal;
   logic [5:0] rd, rs1, rs2;
   logic [3:0] op;

   decodificador_instr u_dec (
      .instr      (ir_q),
      .is_alu     (is_alu),
      .is_long    (is_long),
      .is_nop     (is_nop),
      .is_halt    (is_halt),
      .is_illegal (is_illegal),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .op         (op)
   );

   // State, pc, instruction register and EXEC down-counter
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values;
      // the instruction register is a single word, so it is reset like any flop.
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, pc and counter logic
   always_comb begin
      // NOTE: every variable gets a hold default first so no path infers a latch.
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_halt) begin
               state_d = ST_HALTED;
            end else if (is_alu) begin
               // Counter holds the number of EXEC cycles still to follow
               cnt_d   = is_long ? CNT_W'(LONG_OP_CYCLES - 1) : '0;
               state_d = ST_EXEC;
            end else if (is_nop || is_illegal) begin
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) state_d = ST_WB;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_WB: begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = ST_FETCH;
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state and instruction register
   always_comb begin
      bus.instr_ready   = 1'b0;
      busy              = 1'b0;
      halted            = 1'b0;
      illegal_op        = 1'b0;
      controle          = 4'h0;
      writeRegs         = 1'b0;
      endereco_escrita  = 6'd0;
      endereco_leitura1 = 6'd0;
      endereco_leitura2 = 6'd0;

      bus.instr_ready = (state_q == ST_FETCH);
      busy            = (state_q != ST_IDLE) && (state_q != ST_HALTED);
      halted          = (state_q == ST_HALTED);
      illegal_op      = (state_q == ST_DECODE) && is_illegal;
      writeRegs       = (state_q == ST_WB);

      if ((state_q == ST_EXEC) || (state_q == ST_WB)) controle = op;

      if ((state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB)) begin
         endereco_escrita  = rd;
         endereco_leitura1 = rs1;
         endereco_leitura2 = rs2;
      end
   end

   assign bus.pc = pc_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed scenarios plus a
// randomized instruction stream checked against a per-instruction timeline model.
module tb_unidade_controle;
   localparam int PC_W = 8;
   localparam int LONG = 2;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic [3:0] controle;
   logic       writeRegs;
   logic [5:0] endereco_escrita, endereco_leitura1, endereco_leitura2;
   logic       busy, halted, illegal_op;

   unidade_controle_if #(.PC_WIDTH(PC_W)) bus_if ();

   unidade_controle #(.PC_WIDTH(PC_W), .LONG_OP_CYCLES(LONG)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .bus               (bus_if),
      .controle          (controle),
      .writeRegs         (writeRegs),
      .endereco_escrita  (endereco_escrita),
      .endereco_leitura1 (endereco_leitura1),
      .endereco_leitura2 (endereco_leitura2),
      .busy              (busy),
      .halted            (halted),
      .illegal_op        (illegal_op)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int model_pc = 0;   // expected instruction address, kept modulo 2**PC_W
   int exp_wr = 0;     // expected number of register-file writes so far
   int wr_seen = 0;    // writeRegs high cycles observed

   always @(negedge clock) if (writeRegs === 1'b1) wr_seen++;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // All outputs packed together; the reset value of every field is zero
   function automatic logic [34:0] outs();
      return {bus_if.instr_ready, busy, halted, illegal_op, writeRegs, controle,
              endereco_escrita, endereco_leitura1, endereco_leitura2, bus_if.pc};
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] opc, input logic [5:0] rd,
                                      input logic [5:0] r1, input logic [5:0] r2);
      logic [7:0] lo;
      lo = 8'($urandom);
      return {opc, rd, r1, r2, lo};
   endfunction

   function automatic logic [31:0] rand_instr();
      int kind;
      logic [5:0] opc;
      kind = $urandom_range(0, 9);
      if (kind <= 5)      opc = 6'($urandom_range(0, 15));
      else if (kind <= 7) opc = 6'h10;
      else                opc = 6'($urandom_range(17, 62));
      return mk(opc, 6'($urandom), 6'($urandom), 6'($urandom));
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0;
      bus_if.instr_valid = 1'b0;
      bus_if.instr = '0;
      step();
      reset_n = 1'b1;
      model_pc = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if ({bus_if.instr_ready, busy, bus_if.pc} !== {1'b1, 1'b1, 8'(model_pc)}) begin
         n_err++;
         $display("FAIL start_fetch: got rdy/busy/pc=%b/%b/%0h want 1/1/%0h",
                  bus_if.instr_ready, busy, bus_if.pc, 8'(model_pc));
      end
   endtask

   // Feeds one instruction from FETCH and follows it until the next FETCH
   // (or HALTED), checking every cycle against the expected timeline.
   task automatic run_instr(input logic [31:0] w, input int stall);
      logic [5:0]  opc;
      logic [3:0]  op;
      logic [17:0] regs;
      bit alu, lng, nop, hlt, ill;
      int n_exec;
      opc  = w[31:26];
      alu  = (opc < 6'd16);
      op   = alu ? opc[3:0] : 4'h0;
      lng  = alu && (op >= 4'hE);
      nop  = (opc == 6'h10);
      hlt  = (opc == 6'h3F);
      ill  = !(alu || nop || hlt);
      regs = w[25:8];
      n_exec = lng ? LONG : 1;

      for (int i = 0; i <= stall; i++) begin
         bus_if.instr_valid = (i == stall);
         bus_if.instr = (i == stall) ? w : $urandom;
         n_cmp++;
         if ({bus_if.instr_ready, writeRegs, controle, bus_if.pc} !== {1'b1, 1'b0, 4'h0, 8'(model_pc)}) begin
            n_err++;
            $display("FAIL fetch: got rdy/wr/ctl/pc=%b/%b/%h/%0h want 1/0/0/%0h",
                     bus_if.instr_ready, writeRegs, controle, bus_if.pc, 8'(model_pc));
         end
         step();
      end
      bus_if.instr_valid = 1'b0;
      bus_if.instr = $urandom;

      n_cmp++;
      if ({bus_if.instr_ready, writeRegs, controle, illegal_op, endereco_escrita,
           endereco_leitura1, endereco_leitura2, bus_if.pc} !== {1'b0, 1'b0, 4'h0, ill, regs, 8'(model_pc)}) begin
         n_err++;
         $display("FAIL decode: got rdy/wr/ctl/ill/regs/pc=%b/%b/%h/%b/%h/%0h want 0/0/0/%b/%h/%0h",
                  bus_if.instr_ready, writeRegs, controle, illegal_op,
                  {endereco_escrita, endereco_leitura1, endereco_leitura2}, bus_if.pc, ill, regs, 8'(model_pc));
      end

      if (hlt) begin
         step();
         n_cmp++;
         if ({halted, busy, bus_if.instr_ready, bus_if.pc} !== {1'b1, 1'b0, 1'b0, 8'(model_pc)}) begin
            n_err++;
            $display("FAIL halt: got halted/busy/rdy/pc=%b/%b/%b/%0h want 1/0/0/%0h",
                     halted, busy, bus_if.instr_ready, bus_if.pc, 8'(model_pc));
         end
         return;
      end

      if (!alu) begin
         model_pc = (model_pc + 1) % (1 << PC_W);
         step();
         n_cmp++;
         if ({illegal_op, writeRegs, bus_if.instr_ready, busy, bus_if.pc} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'(model_pc)}) begin
            n_err++;
            $display("FAIL skip_next: got ill/wr/rdy/busy/pc=%b/%b/%b/%b/%0h want 0/0/1/1/%0h",
                     illegal_op, writeRegs, bus_if.instr_ready, busy, bus_if.pc, 8'(model_pc));
         end
         return;
      end

      for (int i = 0; i < n_exec; i++) begin
         step();
         n_cmp++;
         if ({writeRegs, controle, endereco_escrita, endereco_leitura1, endereco_leitura2} !== {1'b0, op, regs}) begin
            n_err++;
            $display("FAIL exec%0d: got wr/ctl/regs=%b/%h/%h want 0/%h/%h", i, writeRegs, controle,
                     {endereco_escrita, endereco_leitura1, endereco_leitura2}, op, regs);
         end
      end

      step();
      exp_wr++;
      n_cmp++;
      if ({writeRegs, controle, endereco_escrita, endereco_leitura1, endereco_leitura2, bus_if.pc} !== {1'b1, op, regs, 8'(model_pc)}) begin
         n_err++;
         $display("FAIL wb: got wr/ctl/regs/pc=%b/%h/%h/%0h want 1/%h/%h/%0h", writeRegs, controle,
                  {endereco_escrita, endereco_leitura1, endereco_leitura2}, bus_if.pc, op, regs, 8'(model_pc));
      end

      model_pc = (model_pc + 1) % (1 << PC_W);
      step();
      n_cmp++;
      if ({bus_if.instr_ready, writeRegs, controle, bus_if.pc} !== {1'b1, 1'b0, 4'h0, 8'(model_pc)}) begin
         n_err++;
         $display("FAIL after_wb: got rdy/wr/ctl/pc=%b/%b/%h/%0h want 1/0/0/%0h",
                  bus_if.instr_ready, writeRegs, controle, bus_if.pc, 8'(model_pc));
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (outs() !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 0", outs());
      end
      repeat (3) step();
      n_cmp++;
      if ({busy, bus_if.instr_ready, bus_if.pc} !== 10'd0) begin
         n_err++;
         $display("FAIL idle_hold: got busy/rdy/pc=%b/%b/%0h want 0/0/0", busy, bus_if.instr_ready, bus_if.pc);
      end
   endtask

   task automatic test_basic_alu();
      do_reset();
      do_start();
      run_instr(32'h0210_8200, 0);
      n_cmp++;
      if (bus_if.pc !== 8'h01) begin
         n_err++;
         $display("FAIL basic_pc: got %0h want 1", bus_if.pc);
      end
   endtask

   task automatic test_long_op();
      run_instr(mk(6'h0E, 6'd5, 6'd6, 6'd7), 0);
      run_instr(mk(6'h0F, 6'd9, 6'd1, 6'd3), 1);
   endtask

   task automatic test_stall();
      run_instr(mk(6'h03, 6'd4, 6'd8, 6'd12), 5);
   endtask

   task automatic test_illegal();
      run_instr(mk(6'h30, 6'd1, 6'd2, 6'd3), 0);
      run_instr(mk(6'h01, 6'd10, 6'd11, 6'd12), 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) run_instr(rand_instr(), $urandom_range(0, 2));
      n_cmp++;
      if (wr_seen !== exp_wr) begin
         n_err++;
         $display("FAIL wr_count: got %0d want %0d", wr_seen, exp_wr);
      end
   endtask

   task automatic test_wrap_and_halt();
      do_reset();
      do_start();
      for (int i = 0; i < 255; i++) run_instr(mk(6'h10, 6'd0, 6'd0, 6'd0), 0);
      run_instr(mk(6'h10, 6'd0, 6'd0, 6'd0), 0);
      n_cmp++;
      if (bus_if.pc !== 8'h00) begin
         n_err++;
         $display("FAIL pc_wrap: got %0h want 0", bus_if.pc);
      end

      do_reset();
      do_start();
      for (int i = 0; i < 255; i++) run_instr(mk(6'h10, 6'd0, 6'd0, 6'd0), 0);
      run_instr(mk(6'h3F, 6'd1, 6'd2, 6'd3), 0);
      start = 1'b1;
      bus_if.instr_valid = 1'b1;
      bus_if.instr = mk(6'h01, 6'd1, 6'd1, 6'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if ({halted, busy, bus_if.instr_ready, writeRegs, bus_if.pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'hFF}) begin
            n_err++;
            $display("FAIL halted_hold: got halted/busy/rdy/wr/pc=%b/%b/%b/%b/%0h want 1/0/0/0/ff",
                     halted, busy, bus_if.instr_ready, writeRegs, bus_if.pc);
         end
      end
      start = 1'b0;
      bus_if.instr_valid = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      do_start();
      run_instr(mk(6'h10, 6'd0, 6'd0, 6'd0), 0);
      bus_if.instr_valid = 1'b1;
      bus_if.instr = mk(6'h0E, 6'd20, 6'd21, 6'd22);
      step();
      bus_if.instr_valid = 1'b0;
      step();
      n_cmp++;
      if (controle !== 4'hE) begin
         n_err++;
         $display("FAIL mid_exec_ctl: got %h want e", controle);
      end
      reset_n = 1'b0;
      step();
      n_cmp++;
      if (outs() !== '0) begin
         n_err++;
         $display("FAIL reset_mid_exec: got %h want 0", outs());
      end
      reset_n = 1'b1;
      model_pc = 0;
      step();
      n_cmp++;
      if ({busy, writeRegs, wr_seen} !== {1'b0, 1'b0, exp_wr}) begin
         n_err++;
         $display("FAIL post_reset_idle: got busy/wr/writes=%b/%b/%0d want 0/0/%0d", busy, writeRegs, wr_seen, exp_wr);
      end
   endtask

   task automatic test_reset_priority();
      do_reset();
      do_start();
      reset_n = 1'b0;
      start = 1'b1;
      bus_if.instr_valid = 1'b1;
      bus_if.instr = mk(6'h02, 6'd1, 6'd1, 6'd1);
      step();
      n_cmp++;
      if (outs() !== '0) begin
         n_err++;
         $display("FAIL reset_priority: got %h want 0", outs());
      end
      reset_n = 1'b1;
      start = 1'b0;
      bus_if.instr_valid = 1'b0;
      step();
      n_cmp++;
      if ({busy, bus_if.instr_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL priority_idle: got busy/rdy=%b/%b want 0/0", busy, bus_if.instr_ready);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      bus_if.instr_valid = 1'b0;
      bus_if.instr = '0;
      test_reset();
      test_basic_alu();
      test_long_op();
      test_stall();
      test_illegal();
      test_random();
      test_wrap_and_halt();
      test_reset_mid_exec();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
